// File: rtl/io_hram_responder.sv
// High I/O page responder: HRAM, IE, IF and the DIV/TIMA/TMA/TAC timer on the core's RE/WE/MAR/databus bus.
// Latency: reads are combinational (same cycle); writes commit on the next rising clk.
// Backpressure: none; every decoded access completes in one cycle, undecoded addresses leave databus floating.
module io_hram_responder #(
    parameter logic [15:0] HRAM_BASE  = 16'hFF80,
    parameter int          HRAM_DEPTH = 127,
    parameter int          DIV_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RE,
    input  logic        WE,
    input  logic [15:0] MAR,
    inout  wire  [7:0]  databus,
    input  logic        vblank_int,
    input  logic        lcdc_int,
    input  logic        serial_int,
    input  logic        joypad_int,
    input  logic        int_ack,
    output logic        sel,
    output logic        irq,
    output logic [2:0]  irq_id
);

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;
    localparam logic [15:0] ADDR_IF   = 16'hFF0F;
    localparam logic [15:0] ADDR_IE   = 16'hFFFF;
    localparam int          AW        = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;
    localparam logic [16:0] HRAM_END  = 17'(HRAM_BASE) + 17'(HRAM_DEPTH);

    // Architectural state
    logic [DIV_W-1:0] cnt;
    logic [7:0]       tima;
    logic [7:0]       tma;
    logic [2:0]       tac;
    logic [4:0]       if_q;
    logic [7:0]       ie;
    logic [7:0]       hram [HRAM_DEPTH];
    logic             t_q;
    logic [4:0]       prev;
    logic [4:0]       armed;

    // Decode
    logic          hit_div, hit_tima, hit_tma, hit_tac, hit_if, hit_ie, hit_hram;
    logic [AW-1:0] hram_idx;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic          we_div, we_tima, we_tma, we_tac, we_if, we_ie, we_hram;

    // Timer and interrupt datapath
    logic       t;
    logic       tick;
    logic       ovf;
    logic [7:0] tma_nxt;
    logic [7:0] tima_nxt;
    logic [4:0] src;
    logic [4:0] set;
    logic [4:0] pend;
    logic [4:0] ack_mask;
    logic [4:0] if_nxt;

    assign hit_div  = (MAR == ADDR_DIV);
    assign hit_tima = (MAR == ADDR_TIMA);
    assign hit_tma  = (MAR == ADDR_TMA);
    assign hit_tac  = (MAR == ADDR_TAC);
    assign hit_if   = (MAR == ADDR_IF);
    assign hit_ie   = (MAR == ADDR_IE);
    assign hit_hram = ({1'b0, MAR} >= {1'b0, HRAM_BASE}) && ({1'b0, MAR} < HRAM_END);
    assign hram_idx = AW'(MAR - HRAM_BASE);
    assign sel      = hit_div | hit_tima | hit_tma | hit_tac | hit_if | hit_ie | hit_hram;

    // The core drives the write byte on the shared bus; RE together with WE is a write.
    assign wdata   = databus;
    assign we_div  = WE & hit_div;
    assign we_tima = WE & hit_tima;
    assign we_tma  = WE & hit_tma;
    assign we_tac  = WE & hit_tac;
    assign we_if   = WE & hit_if;
    assign we_ie   = WE & hit_ie;
    assign we_hram = WE & hit_hram;

    // Read mux; unimplemented bits of TAC and IF read as ones
    always_comb begin
        rdata = 8'h00;
        if (hit_div)       rdata = cnt[DIV_W-1:DIV_W-8];
        else if (hit_tima) rdata = tima;
        else if (hit_tma)  rdata = tma;
        else if (hit_tac)  rdata = {5'b11111, tac};
        else if (hit_if)   rdata = {3'b111, if_q};
        else if (hit_ie)   rdata = ie;
        else if (hit_hram) rdata = hram[hram_idx];
    end

    // Drive only on a pure decoded read so a simultaneous write never contends with the core
    assign databus = (RE & ~WE & sel) ? rdata : 8'bz;

    // Timer input select: divider tap chosen by TAC[1:0], gated by the enable bit
    always_comb begin
        case (tac[1:0])
            2'b00:   t = tac[2] & cnt[9];
            2'b01:   t = tac[2] & cnt[3];
            2'b10:   t = tac[2] & cnt[5];
            default: t = tac[2] & cnt[7];
        endcase
    end

    // Any falling edge of t counts, including ones caused by a DIV reset or TAC change
    assign tick    = t_q & ~t;
    assign tma_nxt = we_tma ? wdata : tma;

    // TIMA next state: CPU write beats a tick; overflow reloads from the freshest TMA
    always_comb begin
        tima_nxt = tima;
        ovf      = 1'b0;
        if (we_tima) begin
            tima_nxt = wdata;
        end else if (tick) begin
            if (tima == 8'hFF) begin
                tima_nxt = tma_nxt;
                ovf      = 1'b1;
            end else begin
                tima_nxt = tima + 8'd1;
            end
        end
    end

    // Rising-edge detect; a source is only armed once it has been seen low after reset,
    // so a request held high across reset release does not fire
    assign src  = {joypad_int, serial_int, ovf, lcdc_int, vblank_int};
    assign set  = src & ~prev & armed;
    assign pend = ie[4:0] & if_q;
    assign irq  = |pend;

    // Lowest pending index wins
    always_comb begin
        irq_id = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (pend[k]) irq_id = 3'(k);
        end
    end

    assign ack_mask = (int_ack & irq) ? (5'd1 << irq_id) : 5'd0;
    assign if_nxt   = ((we_if ? wdata[4:0] : if_q) & ~ack_mask) | set;

    // Timer, interrupt and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            tima  <= 8'h00;
            tma   <= 8'h00;
            tac   <= 3'b000;
            if_q  <= 5'b00000;
            ie    <= 8'h00;
            t_q   <= 1'b0;
            prev  <= 5'b00000;
            armed <= 5'b00000;
        end else begin
            cnt   <= we_div ? '0 : cnt + 1'b1;
            t_q   <= t;
            tima  <= tima_nxt;
            tma   <= tma_nxt;
            if (we_tac) tac <= wdata[2:0];
            if (we_ie)  ie  <= wdata;
            if_q  <= if_nxt;
            prev  <= src;
            armed <= armed | ~src;
        end
    end

    // HRAM storage, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HRAM_DEPTH; i++) hram[i] <= 8'h00;
        end else if (we_hram) begin
            hram[hram_idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_io_hram_responder.sv
module tb_io_hram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        RE, WE;
    logic [15:0] MAR;
    logic        vblank_int, lcdc_int, serial_int, joypad_int, int_ack;
    logic        sel, irq;
    logic [2:0]  irq_id;
    logic [7:0]  drv;
    logic        drv_en;
    // Pulled up so a floating bus reads 8'hFF
    tri1  [7:0]  databus;

    assign databus = drv_en ? drv : 8'bz;

    io_hram_responder dut (
        .clk(clk), .rst(rst), .RE(RE), .WE(WE), .MAR(MAR), .databus(databus),
        .vblank_int(vblank_int), .lcdc_int(lcdc_int), .serial_int(serial_int),
        .joypad_int(joypad_int), .int_ack(int_ack),
        .sel(sel), .irq(irq), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic        wr;
        logic        re_too;
        logic [15:0] addr;
        logic [7:0]  dat;
        logic        exp_sel;
        logic [7:0]  exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        MAR = addr; drv = data; drv_en = 1'b1; WE = 1'b1;
        @(negedge clk);
        WE = 1'b0; drv_en = 1'b0;
    endtask

    // Expected value queued at stimulus time, popped when the bus is sampled
    task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input string name);
        exp_t e;
        e.name = name; e.val = exp;
        sb.push_back(e);
        @(negedge clk);
        MAR = addr; RE = 1'b1;
        #1;
        e = sb.pop_front();
        chk(e.name, databus, e.val);
        RE = 1'b0;
    endtask

    task automatic peek(input logic [15:0] addr, output logic [7:0] v);
        @(negedge clk);
        MAR = addr; RE = 1'b1;
        #1;
        v = databus;
        RE = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        MAR = v.addr; WE = v.wr; RE = !v.wr || v.re_too;
        drv = v.dat; drv_en = v.wr;
        #1;
        chk({v.name, " sel"}, sel, v.exp_sel);
        if (!v.wr) begin
            e.name = v.name; e.val = v.exp_rd;
            sb.push_back(e);
            e = sb.pop_front();
            chk(e.name, databus, e.val);
        end else begin
            @(negedge clk);
        end
        WE = 1'b0; RE = 1'b0; drv_en = 1'b0;
    endtask

    vec_t vecs[$];
    logic [7:0] v, prev_v;
    int   ch1, ch2;
    logic [7:0] val1, val2;
    logic irq_at1, irq_at2;
    logic [2:0] id_at2;

    initial begin
        rst = 1'b1; RE = 1'b0; WE = 1'b0; MAR = 16'h0000; drv = 8'h00; drv_en = 1'b0;
        vblank_int = 1'b0; lcdc_int = 1'b0; serial_int = 1'b0; joypad_int = 1'b0; int_ack = 1'b0;

        // Reset state, including a decoded read while reset is held
        repeat (3) @(negedge clk);
        rd(16'hFF07, 8'hF8, "tac_in_reset");
        chk("irq_in_reset", irq, 1'b0);
        chk("irq_id_in_reset", irq_id, 3'd0);
        @(negedge clk); rst = 1'b0;
        rd(16'hFF04, 8'h00, "rst_div");
        rd(16'hFF05, 8'h00, "rst_tima");
        rd(16'hFF06, 8'h00, "rst_tma");
        rd(16'hFF0F, 8'hE0, "rst_if");
        rd(16'hFFFF, 8'h00, "rst_ie");
        rd(16'hFF80, 8'h00, "rst_hram");

        // Decode / storage vectors
        vecs.push_back('{"w_ff80",  1'b1, 1'b0, 16'hFF80, 8'hA5, 1'b1, 8'h00});
        vecs.push_back('{"w_fffe",  1'b1, 1'b0, 16'hFFFE, 8'h3C, 1'b1, 8'h00});
        vecs.push_back('{"r_ff80",  1'b0, 1'b0, 16'hFF80, 8'h00, 1'b1, 8'hA5});
        vecs.push_back('{"r_fffe",  1'b0, 1'b0, 16'hFFFE, 8'h00, 1'b1, 8'h3C});
        vecs.push_back('{"r_ff7f",  1'b0, 1'b0, 16'hFF7F, 8'h00, 1'b0, 8'hFF});
        vecs.push_back('{"r_ff00",  1'b0, 1'b0, 16'hFF00, 8'h00, 1'b0, 8'hFF});
        vecs.push_back('{"w_ff10",  1'b1, 1'b0, 16'hFF10, 8'h12, 1'b0, 8'h00});
        vecs.push_back('{"r_ff10",  1'b0, 1'b0, 16'hFF10, 8'h00, 1'b0, 8'hFF});
        vecs.push_back('{"w_ie",    1'b1, 1'b0, 16'hFFFF, 8'h5A, 1'b1, 8'h00});
        vecs.push_back('{"r_ie",    1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b1, 8'h5A});
        vecs.push_back('{"w_tma",   1'b1, 1'b0, 16'hFF06, 8'h81, 1'b1, 8'h00});
        vecs.push_back('{"r_tma",   1'b0, 1'b0, 16'hFF06, 8'h00, 1'b1, 8'h81});
        vecs.push_back('{"w_tima",  1'b1, 1'b0, 16'hFF05, 8'h33, 1'b1, 8'h00});
        vecs.push_back('{"r_tima",  1'b0, 1'b0, 16'hFF05, 8'h00, 1'b1, 8'h33});
        vecs.push_back('{"wr_both", 1'b1, 1'b1, 16'hFF81, 8'h6C, 1'b1, 8'h00});
        vecs.push_back('{"r_ff81",  1'b0, 1'b0, 16'hFF81, 8'h00, 1'b1, 8'h6C});
        vecs.push_back('{"w_tac",   1'b1, 1'b0, 16'hFF07, 8'hFE, 1'b1, 8'h00});
        vecs.push_back('{"r_tac",   1'b0, 1'b0, 16'hFF07, 8'h00, 1'b1, 8'hFE});
        foreach (vecs[i]) apply(vecs[i]);

        // Timer: TAC=101 ticks every 16 clk, overflow reloads TMA and raises IF[2]
        wr(16'hFF07, 8'h00);
        wr(16'hFF04, 8'h00);
        wr(16'hFFFF, 8'h04);
        wr(16'hFF06, 8'hF0);
        wr(16'hFF05, 8'hFE);
        wr(16'hFF07, 8'h05);
        ch1 = -1; ch2 = -1; val1 = 8'h00; val2 = 8'h00;
        irq_at1 = 1'b1; irq_at2 = 1'b0; id_at2 = 3'd7;
        prev_v = 8'hFE;
        for (int i = 0; i < 60; i++) begin
            peek(16'hFF05, v);
            if (v !== prev_v) begin
                if (ch1 < 0) begin ch1 = i; val1 = v; irq_at1 = irq; end
                else if (ch2 < 0) begin ch2 = i; val2 = v; irq_at2 = irq; id_at2 = irq_id; end
            end
            prev_v = v;
        end
        chk("tima_tick1", val1, 8'hFF);
        chk("irq_before_ovf", irq_at1, 1'b0);
        chk("tima_reload", val2, 8'hF0);
        chk("tick_period", ch2 - ch1, 16);
        chk("irq_on_ovf", irq_at2, 1'b1);
        chk("irq_id_ovf", id_at2, 3'd2);
        rd(16'hFF0F, 8'hE4, "if_timer");
        wr(16'hFF07, 8'h00);

        // Simultaneous sources: lowest index wins, ack clears only that bit
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h00);
        @(negedge clk); vblank_int = 1'b1; joypad_int = 1'b1;
        rd(16'hFF0F, 8'hF1, "if_two_src");
        chk("irq_two_src", irq, 1'b1);
        chk("irq_id_two_src", irq_id, 3'd0);
        @(negedge clk); int_ack = 1'b1;
        @(negedge clk); int_ack = 1'b0;
        rd(16'hFF0F, 8'hF0, "if_after_ack");
        chk("irq_id_after_ack", irq_id, 3'd4);
        vblank_int = 1'b0; joypad_int = 1'b0;

        // Set beats a write-clear of the same register in the same cycle
        @(negedge clk);
        MAR = 16'hFF0F; drv = 8'h00; drv_en = 1'b1; WE = 1'b1; serial_int = 1'b1;
        @(negedge clk);
        WE = 1'b0; drv_en = 1'b0;
        rd(16'hFF0F, 8'hE8, "if_set_wins");
        chk("irq_id_serial", irq_id, 3'd3);

        // Ack with no pending irq is ignored
        wr(16'hFFFF, 8'h00);
        @(negedge clk); int_ack = 1'b1;
        @(negedge clk); int_ack = 1'b0;
        rd(16'hFF0F, 8'hE8, "if_ack_no_irq");
        chk("irq_masked", irq, 1'b0);

        // DIV: write clears the divider regardless of data
        wr(16'hFF04, 8'h00);
        repeat (16'h1200) @(posedge clk);
        rd(16'hFF04, 8'h12, "div_12");
        wr(16'hFF04, 8'h77);
        rd(16'hFF04, 8'h00, "div_cleared");
        repeat (254) @(posedge clk);
        rd(16'hFF04, 8'h00, "div_255");
        @(posedge clk);
        rd(16'hFF04, 8'h01, "div_256");

        // Reset mid-operation with a source held high
        @(negedge clk); lcdc_int = 1'b1;
        rd(16'hFF0F, 8'hEA, "if_lcdc");
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        rd(16'hFF0F, 8'hE0, "if_after_rst");
        rd(16'hFF80, 8'h00, "hram_after_rst");
        rd(16'hFFFE, 8'h00, "hram2_after_rst");
        rd(16'hFFFF, 8'h00, "ie_after_rst");
        rd(16'hFF06, 8'h00, "tma_after_rst");
        rd(16'hFF05, 8'h00, "tima_after_rst");
        rd(16'hFF07, 8'hF8, "tac_after_rst");
        rd(16'hFF04, 8'h00, "div_after_rst");
        @(negedge clk); lcdc_int = 1'b0;
        rd(16'hFF0F, 8'hE0, "if_lcdc_low");
        @(negedge clk); lcdc_int = 1'b1;
        rd(16'hFF0F, 8'hE2, "if_lcdc_rearmed");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
